fetch_unit: RTL and testbench

- Instruction fetch stage, directly upstream of the instruction decoder.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched 32-bit word to the decoder on `instruction` with `enable` as the valid strobe.
- Holds the word under downstream stall and redirects on taken branches, discarding in-flight fetches.

---
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: one outstanding word request, acked by a one-cycle strobe.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [31:0]           imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time and hands it to the decoder,
// holding it under stall and redirecting on taken branches.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_unit_if.master          imem,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [31:0]           instruction,
    output logic                  enable,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] pc_plus8
);
    typedef enum logic [1:0] {IDLE, FETCH, FLUSH, DELIVER} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q, addr_q, ipc_q, pc8_q;
    logic [31:0]           instr_q;
    logic                  req_q, en_q;
    logic [ADDR_WIDTH-1:0] tgt_d, pc4_d, pc8_d;

    assign tgt_d = branch_target & ~ADDR_WIDTH'(3);
    assign pc4_d = pc_q + ADDR_WIDTH'(4);
    assign pc8_d = pc_q + ADDR_WIDTH'(8);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            instr_q <= '0;
            en_q    <= 1'b0;
            ipc_q   <= '0;
            pc8_q   <= ADDR_WIDTH'(8);
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    pc_q    <= branch_taken ? tgt_d : pc_q;
                    addr_q  <= branch_taken ? tgt_d : pc_q;
                end
                FETCH: begin
                    if (branch_taken) begin
                        pc_q <= tgt_d;
                        // A live request cannot be withdrawn: without ack, drain it in FLUSH.
                        if (imem.imem_ack) addr_q  <= tgt_d;
                        else               state_q <= FLUSH;
                    end else if (imem.imem_ack) begin
                        instr_q <= imem.imem_rdata;
                        ipc_q   <= pc_q;
                        pc8_q   <= pc8_d;
                        pc_q    <= pc4_d;
                        en_q    <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= DELIVER;
                    end
                end
                FLUSH: begin
                    if (branch_taken) pc_q <= tgt_d;
                    if (imem.imem_ack) begin
                        state_q <= FETCH;
                        addr_q  <= branch_taken ? tgt_d : pc_q;
                    end
                end
                DELIVER: begin
                    if (branch_taken || !stall) begin
                        en_q    <= 1'b0;
                        req_q   <= 1'b1;
                        pc_q    <= branch_taken ? tgt_d : pc_q;
                        addr_q  <= branch_taken ? tgt_d : pc_q;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign instruction    = instr_q;
    assign enable         = en_q;
    assign instr_pc       = ipc_q;
    assign pc_plus8       = pc8_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench: two fetch units (RESET_PC 0 and 0xFFFF_FFFC) against a latency-programmable memory.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, reset2;
    logic        stall, branch_taken, stall2, branch2;
    logic [31:0] branch_target, target2;
    logic [31:0] instruction, instruction2, instr_pc, instr_pc2, pc_plus8, pc_plus82;
    logic        enable, enable2;
    int          n_chk = 0, n_err = 0;
    int          lat = 1, w1 = 0, w2 = 0;

    fetch_unit_if #(.ADDR_WIDTH(32)) bus ();
    fetch_unit_if #(.ADDR_WIDTH(32)) bus2 ();

    fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .imem(bus.master), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instruction(instruction), .enable(enable), .instr_pc(instr_pc), .pc_plus8(pc_plus8)
    );

    fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset2), .imem(bus2.master), .stall(stall2),
        .branch_taken(branch2), .branch_target(target2),
        .instruction(instruction2), .enable(enable2), .instr_pc(instr_pc2), .pc_plus8(pc_plus82)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Ack in the lat-th consecutive request cycle; lat=1 is zero-wait.
    task automatic mem_drive();
        if (reset || !bus.imem_req) begin
            bus.imem_ack = 1'b0; w1 = 0;
        end else begin
            w1++;
            bus.imem_ack   = (w1 >= lat);
            bus.imem_rdata = (w1 >= lat) ? memf(bus.imem_addr) : 32'hDEAD_BEEF;
            if (w1 >= lat) w1 = 0;
        end
        if (reset2 || !bus2.imem_req) begin
            bus2.imem_ack = 1'b0; w2 = 0;
        end else begin
            bus2.imem_ack   = 1'b1;
            bus2.imem_rdata = memf(bus2.imem_addr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_drive();
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        stall2 = 1'b0; branch2 = 1'b0; target2 = '0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        bus2.imem_ack = 1'b0; bus2.imem_rdata = '0;
        tick(); tick();
        chk("rst req", 32'(bus.imem_req), 32'd0);
        chk("rst addr", bus.imem_addr, 32'h0);
        chk("rst instr", instruction, 32'h0);
        chk("rst en", 32'(enable), 32'd0);
        chk("rst ipc", instr_pc, 32'h0);
        chk("rst pc8", pc_plus8, 32'h8);
        chk("rst2 addr", bus2.imem_addr, 32'hFFFF_FFFC);
        chk("rst2 pc8", pc_plus82, 32'h8);

        reset = 1'b0;
        tick();                                   // cycle 1
        chk("c1 req", 32'(bus.imem_req), 32'd1);
        chk("c1 addr", bus.imem_addr, 32'h0);
        chk("c1 en", 32'(enable), 32'd0);
        tick();                                   // cycle 2
        chk("c2 en", 32'(enable), 32'd1);
        chk("c2 instr", instruction, memf(32'h0));
        chk("c2 ipc", instr_pc, 32'h0);
        chk("c2 pc8", pc_plus8, 32'h8);
        chk("c2 req", 32'(bus.imem_req), 32'd0);
        lat = 3;
        tick();                                   // cycle 3
        chk("c3 req", 32'(bus.imem_req), 32'd1);
        chk("c3 addr", bus.imem_addr, 32'h4);

        for (int i = 0; i < 2; i++) begin         // cycles 4,5: still waiting
            tick();
            chk("wait req", 32'(bus.imem_req), 32'd1);
            chk("wait addr", bus.imem_addr, 32'h4);
            chk("wait en", 32'(enable), 32'd0);
        end
        lat = 1;
        tick();                                   // cycle 6
        chk("lat en", 32'(enable), 32'd1);
        chk("lat instr", instruction, memf(32'h4));
        chk("lat ipc", instr_pc, 32'h4);
        chk("lat pc8", pc_plus8, 32'hC);
        tick();                                   // cycle 7
        chk("pulse en", 32'(enable), 32'd0);
        chk("c7 addr", bus.imem_addr, 32'h8);
        tick();                                   // cycle 8
        chk("c8 en", 32'(enable), 32'd1);
        chk("c8 ipc", instr_pc, 32'h8);

        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall en", 32'(enable), 32'd1);
            chk("stall ipc", instr_pc, 32'h8);
            chk("stall instr", instruction, memf(32'h8));
            chk("stall req", 32'(bus.imem_req), 32'd0);
        end
        stall = 1'b0; lat = 3;
        tick();                                   // cycle 14
        chk("unstall req", 32'(bus.imem_req), 32'd1);
        chk("unstall addr", bus.imem_addr, 32'hC);
        chk("unstall en", 32'(enable), 32'd0);

        branch_taken = 1'b1; branch_target = 32'h103;
        tick();                                   // cycle 15: FLUSH
        branch_taken = 1'b0;
        chk("flush req", 32'(bus.imem_req), 32'd1);
        chk("flush addr", bus.imem_addr, 32'hC);
        tick();                                   // cycle 16: ack of stale fetch
        chk("flush addr2", bus.imem_addr, 32'hC);
        chk("flush en", 32'(enable), 32'd0);
        lat = 1;
        tick();                                   // cycle 17
        chk("redir addr", bus.imem_addr, 32'h100);
        chk("redir req", 32'(bus.imem_req), 32'd1);
        chk("stale en", 32'(enable), 32'd0);
        tick();                                   // cycle 18
        chk("br en", 32'(enable), 32'd1);
        chk("br ipc", instr_pc, 32'h100);
        chk("br instr", instruction, memf(32'h100));
        chk("br pc8", pc_plus8, 32'h108);

        tick();                                   // cycle 19: FETCH 0x104 with ack
        chk("c19 addr", bus.imem_addr, 32'h104);
        branch_taken = 1'b1; branch_target = 32'h200;
        tick();                                   // cycle 20
        branch_taken = 1'b0;
        chk("brack en", 32'(enable), 32'd0);
        chk("brack addr", bus.imem_addr, 32'h200);
        chk("brack req", 32'(bus.imem_req), 32'd1);
        tick();                                   // cycle 21
        chk("brack ipc", instr_pc, 32'h200);
        chk("brack instr", instruction, memf(32'h200));

        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h302;
        tick();                                   // cycle 22
        stall = 1'b0; branch_taken = 1'b0;
        chk("brstl en", 32'(enable), 32'd0);
        chk("brstl addr", bus.imem_addr, 32'h300);
        tick();                                   // cycle 23
        chk("brstl ipc", instr_pc, 32'h300);
        chk("brstl instr", instruction, memf(32'h300));

        reset2 = 1'b0;
        tick();
        chk("wrap req", 32'(bus2.imem_req), 32'd1);
        chk("wrap addr", bus2.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap en", 32'(enable2), 32'd1);
        chk("wrap ipc", instr_pc2, 32'hFFFF_FFFC);
        chk("wrap pc8", pc_plus82, 32'h4);
        chk("wrap instr", instruction2, memf(32'hFFFF_FFFC));
        tick();
        chk("wrap addr2", bus2.imem_addr, 32'h0);
        chk("wrap req2", 32'(bus2.imem_req), 32'd1);
        reset2 = 1'b1;
        tick();
        chk("abort req", 32'(bus2.imem_req), 32'd0);
        chk("abort addr", bus2.imem_addr, 32'hFFFF_FFFC);
        chk("abort en", 32'(enable2), 32'd0);
        reset2 = 1'b0;
        tick();
        chk("restart req", 32'(bus2.imem_req), 32'd1);
        chk("restart addr", bus2.imem_addr, 32'hFFFF_FFFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
